// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
package dma_pkg;

    localparam int DMA_MAX_CH = 16;
    localparam int DMA_IDX_W  = $clog2(DMA_MAX_CH);

    typedef enum logic {ARB_IDLE, ARB_GRANTED} arbState_t;

    function automatic logic [DMA_MAX_CH-1:0] onehot(input logic [DMA_IDX_W-1:0] idx);
        logic [DMA_MAX_CH-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Rotating first-one search: returns the first active request at or after
// startIdx, wrapping modulo NUM_CH.
module dma_prio_encoder #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  startIdx,
    output logic              found,
    output logic [IDX_W-1:0]  winIdx
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [IDX_W-1:0]    off;
    logic [IDX_W:0]      sum;

    // Doubling the vector lets a plain shift expose the wrapped search order.
    assign dbl = {req, req};
    assign rot = NUM_CH'(dbl >> startIdx);

    always_comb begin
        found = |rot;
        off   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) off = IDX_W'(k);
        end
        sum = {1'b0, startIdx} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NUM_CH))
            winIdx = IDX_W'(sum - (IDX_W+1)'(NUM_CH));
        else
            winIdx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Registered DMA channel arbiter: fixed/rotating priority, masking,
// programmable DREQ/DACK polarity, grant held until xferDone.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              priorityType,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              arbEnable,
    input  logic              xferDone,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [IDX_W-1:0]  grantIdx,
    output logic              reqPending
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    arbState_t         state, stateNxt;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] dackRaw;
    logic [IDX_W-1:0]  prioPtr;
    logic [IDX_W-1:0]  startIdx;
    logic [IDX_W-1:0]  winIdx;
    logic              found;
    logic              latchGrant;
    logic              releaseGrant;

    assign req      = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;
    assign startIdx = priorityType ? prioPtr : '0;

    dma_prio_encoder #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) uEnc (
        .req      (req),
        .startIdx (startIdx),
        .found    (found),
        .winIdx   (winIdx)
    );

    always_comb begin
        stateNxt     = state;
        latchGrant   = 1'b0;
        releaseGrant = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (arbEnable && found) begin
                    latchGrant = 1'b1;
                    stateNxt   = ARB_GRANTED;
                end
            end
            ARB_GRANTED: begin
                if (xferDone) begin
                    releaseGrant = 1'b1;
                    stateNxt     = ARB_IDLE;
                end
            end
            default: stateNxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ARB_IDLE;
            grantIdx   <= '0;
            prioPtr    <= '0;
            reqPending <= 1'b0;
        end else begin
            state      <= stateNxt;
            reqPending <= |req;
            if (latchGrant)
                grantIdx <= winIdx;
            else if (releaseGrant)
                grantIdx <= '0;
            // Served channel drops to lowest priority; fixed mode keeps the pointer.
            if (releaseGrant && priorityType)
                prioPtr <= (grantIdx == LAST_IDX) ? '0 : grantIdx + IDX_W'(1);
        end
    end

    assign grantValid = (state == ARB_GRANTED);
    assign dackRaw    = grantValid ? NUM_CH'(onehot(DMA_IDX_W'(grantIdx))) : '0;
    assign DACK       = dackRaw ^ {NUM_CH{~dackSenseHigh}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: NUM_CH=4 and NUM_CH=8 instances checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_dma_priority_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic        rst   [2];
    logic [15:0] dreq  [2];
    logic [15:0] mask  [2];
    logic        prio  [2];
    logic        dsl   [2];
    logic        dsh   [2];
    logic        arbEn [2];
    logic        xdone [2];

    logic [3:0] dack4;  logic gv4;  logic [1:0] gi4;  logic rp4;
    logic [7:0] dack8;  logic gv8;  logic [2:0] gi8;  logic rp8;

    dma_priority_arbiter #(.NUM_CH(4)) dut4 (
        .CLK(CLK), .RESET(rst[0]), .DREQ(dreq[0][3:0]), .maskReg(mask[0][3:0]),
        .priorityType(prio[0]), .dreqSenseLow(dsl[0]), .dackSenseHigh(dsh[0]),
        .arbEnable(arbEn[0]), .xferDone(xdone[0]),
        .DACK(dack4), .grantValid(gv4), .grantIdx(gi4), .reqPending(rp4)
    );

    dma_priority_arbiter #(.NUM_CH(8)) dut8 (
        .CLK(CLK), .RESET(rst[1]), .DREQ(dreq[1][7:0]), .maskReg(mask[1][7:0]),
        .priorityType(prio[1]), .dreqSenseLow(dsl[1]), .dackSenseHigh(dsh[1]),
        .arbEnable(arbEn[1]), .xferDone(xdone[1]),
        .DACK(dack8), .grantValid(gv8), .grantIdx(gi8), .reqPending(rp8)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model
    int          nch  [2] = '{4, 8};
    logic [15:0] lim  [2] = '{16'h000f, 16'h00ff};
    bit          mGv  [2] = '{0, 0};
    int          mGi  [2] = '{0, 0};
    int          mPtr [2] = '{0, 0};
    bit          mPend[2] = '{0, 0};
    logic [15:0] mReq [2];

    function automatic int winner(input logic [15:0] r, input int start, input int n);
        for (int k = 0; k < n; k++)
            if (r[(start + k) % n]) return (start + k) % n;
        return 0;
    endfunction

    function automatic logic [15:0] expDack(input int d);
        logic [15:0] v;
        v = mGv[d] ? (16'h1 << mGi[d]) : 16'h0;
        return v ^ (dsh[d] ? 16'h0 : lim[d]);
    endfunction

    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            mReq[d] = (dreq[d] ^ {16{dsl[d]}}) & ~mask[d] & lim[d];
            if (rst[d]) begin
                mGv[d] = 0; mGi[d] = 0; mPtr[d] = 0; mPend[d] = 0;
            end else begin
                if (!mGv[d]) begin
                    if (arbEn[d] && mReq[d] != 0) begin
                        mGi[d] = winner(mReq[d], prio[d] ? mPtr[d] : 0, nch[d]);
                        mGv[d] = 1;
                    end
                end else if (xdone[d]) begin
                    if (prio[d]) mPtr[d] = (mGi[d] + 1) % nch[d];
                    mGv[d] = 0;
                    mGi[d] = 0;
                end
                mPend[d] = (mReq[d] != 0);
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("m_dack4", 16'(dack4), expDack(0));
        chk("m_gv4",   16'(gv4),   16'(mGv[0]));
        chk("m_gi4",   16'(gi4),   16'(mGi[0]));
        chk("m_rp4",   16'(rp4),   16'(mPend[0]));
        chk("m_dack8", 16'(dack8), expDack(1));
        chk("m_gv8",   16'(gv8),   16'(mGv[1]));
        chk("m_gi8",   16'(gi8),   16'(mGi[1]));
        chk("m_rp8",   16'(rp8),   16'(mPend[1]));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    int seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; dreq[d] = 0; mask[d] = 0; prio[d] = 0;
            dsl[d] = 0; dsh[d] = 1; arbEn[d] = 0; xdone[d] = 0;
        end
        tick(2);
        chk("rst_dack4", 16'(dack4), 16'h0);
        chk("rst_gv4",   16'(gv4),   16'h0);
        chk("rst_gi4",   16'(gi4),   16'h0);
        chk("rst_rp4",   16'(rp4),   16'h0);
        chk("rst_dack8", 16'(dack8), 16'h0);
        rst[0] = 0; rst[1] = 0;

        // Fixed priority, grant held, then next arbitration
        dreq[0] = 16'hA; arbEn[0] = 1;
        tick;
        chk("fix_dack", 16'(dack4), 16'h2);
        chk("fix_pend", 16'(rp4),   16'h1);
        dreq[0] = 16'h1;
        tick(2);
        chk("fix_hold", 16'(dack4), 16'h2);
        dreq[0] = 16'h8; xdone[0] = 1;
        tick;
        chk("fix_rel", 16'(dack4), 16'h0);
        xdone[0] = 0;
        tick;
        chk("fix_next", 16'(dack4), 16'h8);
        xdone[0] = 1; tick; xdone[0] = 0; arbEn[0] = 0; dreq[0] = 0;
        xdone[0] = 1; tick; xdone[0] = 0;
        chk("idle_xdone", 16'(gv4), 16'h0);

        // Rotating, all requesting
        prio[0] = 1; dreq[0] = 16'hF; arbEn[0] = 1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rot_grant", 16'(gi4), 16'(seq[i]));
            xdone[0] = 1;
            tick;
            chk("rot_gap", 16'(gv4), 16'h0);
            xdone[0] = 0;
        end
        tick;
        chk("rot_ptr", 16'(gi4), 16'h1);
        xdone[0] = 1; tick; xdone[0] = 0; arbEn[0] = 0; dreq[0] = 0;

        // Masking, including mid-grant mask change
        prio[0] = 0; mask[0] = 16'h1; dreq[0] = 16'h3; arbEn[0] = 1;
        tick;
        chk("mask_dack", 16'(dack4), 16'h2);
        mask[0] = 16'h3;
        tick;
        chk("mask_hold", 16'(dack4), 16'h2);
        xdone[0] = 1; tick; xdone[0] = 0;
        chk("mask_rel", 16'(dack4), 16'h0);
        tick;
        chk("mask_none", 16'(gv4), 16'h0);
        chk("mask_pend", 16'(rp4), 16'h0);
        mask[0] = 0; dreq[0] = 0; arbEn[0] = 0;
        tick;

        // Polarity
        dsl[0] = 1; dsh[0] = 0; dreq[0] = 16'hB; arbEn[0] = 1;
        tick;
        chk("pol_dack", 16'(dack4), 16'hB);
        chk("pol_gi",   16'(gi4),   16'h2);
        xdone[0] = 1; tick; xdone[0] = 0; arbEn[0] = 0;
        chk("pol_idle", 16'(dack4), 16'hF);
        rst[0] = 1; tick; rst[0] = 0;
        chk("pol_rst", 16'(dack4), 16'hF);
        dsl[0] = 0; dsh[0] = 1; dreq[0] = 0;

        // Reset mid-grant with prioPtr = 2
        prio[0] = 1; dreq[0] = 16'h2; arbEn[0] = 1;
        tick;
        chk("rr_g1", 16'(gi4), 16'h1);
        xdone[0] = 1; dreq[0] = 16'hF;
        tick;
        xdone[0] = 0;
        tick;
        chk("rr_g2", 16'(gi4), 16'h2);
        rst[0] = 1; tick; rst[0] = 0;
        chk("rr_gv",   16'(gv4),   16'h0);
        chk("rr_dack", 16'(dack4), 16'h0);
        tick;
        chk("rr_g0", 16'(gi4), 16'h0);
        xdone[0] = 1; tick; xdone[0] = 0; arbEn[0] = 0; dreq[0] = 0;

        // NUM_CH=8 wrap from channel 7 to channel 0
        prio[1] = 1; arbEn[1] = 1; dreq[1] = 16'h40;
        tick;
        chk("w8_g6", 16'(gi8), 16'h6);
        xdone[1] = 1; dreq[1] = 16'h81;
        tick;
        xdone[1] = 0;
        tick;
        chk("w8_g7",   16'(gi8),   16'h7);
        chk("w8_dack", 16'(dack8), 16'h80);
        xdone[1] = 1; tick; xdone[1] = 0;
        tick;
        chk("w8_g0", 16'(gi8), 16'h0);
        xdone[1] = 1; tick; xdone[1] = 0; arbEn[1] = 0; dreq[1] = 0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
